// File: rtl/count_down_timer.sv
// count_down_timer
//   Loadable, saturating down-counter used as a phase/interval timer by the
//   traffic-light controller. A value is loaded, and the count then steps
//   down by one on each enabled clock until it reaches zero, where it holds.
//
//   Ports:
//     clk          rising-edge clock for all state
//     reset        asynchronous, active-low reset (count -> 0, max -> all-ones)
//     down         decrement enable
//     load         synchronous load strobe, has priority over down
//     in           value captured into the count when load=1
//     currentCount present count, straight from the register
//
// sat_updown_counter
//   Generic saturating up/down counter with a loadable ceiling (max). It is
//   shared with other blocks, so the up path and the max load are complete
//   even though the timer leaves them idle.
//
//   Ports:
//     clk, reset   as above
//     up / down    step enables; both high means hold
//     load, in     load the count (clipped to the current max)
//     loadMax      load the ceiling from maxIn
//     count        registered count

module sat_updown_counter #(
    parameter int BIT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 up,
    input  logic                 down,
    input  logic                 load,
    input  logic                 loadMax,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic [BIT_WIDTH-1:0] maxIn,
    output logic [BIT_WIDTH-1:0] count
);

    logic [BIT_WIDTH-1:0] max;
    logic [BIT_WIDTH-1:0] max_next;
    logic [BIT_WIDTH-1:0] count_next;
    logic [BIT_WIDTH-1:0] load_val;

    always_comb begin
        max_next   = max;
        load_val   = in;
        count_next = count;

        if (loadMax) begin
            max_next = maxIn;
        end

        // A load above the ceiling is clipped; with max at all-ones this
        // never triggers.
        if (in > max) begin
            load_val = max;
        end

        // in is only looked at under load, so an undriven in cannot
        // disturb the count while load is low.
        if (load) begin
            count_next = load_val;
        end else if (up && !down) begin
            // >= also pulls the count back down if max was lowered below it.
            if (count >= max) begin
                count_next = max;
            end else begin
                count_next = count + 1'b1;
            end
        end else if (down && !up) begin
            if (count != '0) begin
                count_next = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            max   <= '1;
        end else begin
            count <= count_next;
            max   <= max_next;
        end
    end

endmodule

module count_down_timer #(
    parameter int BIT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 down,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0] currentCount
);

    localparam logic [BIT_WIDTH-1:0] ALL_ONES = '1;

    logic [BIT_WIDTH-1:0] count;

    // The ceiling stays at its reset value of all-ones, so every load value
    // is accepted unclipped and the up path is never used.
    sat_updown_counter #(
        .BIT_WIDTH (BIT_WIDTH)
    ) counter (
        .clk     (clk),
        .reset   (reset),
        .up      (1'b0),
        .down    (down),
        .load    (load),
        .loadMax (1'b0),
        .in      (in),
        .maxIn   (ALL_ONES),
        .count   (count)
    );

    assign currentCount = count;

endmodule

// File: tb/tb_count_down_timer.sv
module tb_count_down_timer;

    localparam int W = 5;

    typedef struct {
        string       tag;
        int unsigned exp;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         down = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] in_val = '0;
    logic [W-1:0] current_count;

    exp_t        sb[$];
    int unsigned model_count = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    count_down_timer #(
        .BIT_WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .down         (down),
        .load         (load),
        .in           (in_val),
        .currentCount (current_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one edge's worth of stimulus, push the model's prediction, then
    // pop and compare after the edge.
    task automatic drive(input string tag, input logic ld, input logic dn, input logic [W-1:0] v);
        exp_t e;
        @(negedge clk);
        load   = ld;
        down   = dn;
        in_val = v;
        if (ld) begin
            model_count = int'(v);
        end else if (dn && model_count > 0) begin
            model_count = model_count - 1;
        end
        sb.push_back('{tag, model_count});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {27'd0, current_count}, e.exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        in_val = '0;
        #1;
        check("rst_count_async", {27'd0, current_count}, 0);
        @(posedge clk);
        #1;
        check("rst_count_held", {27'd0, current_count}, 0);
        check("rst_max", {27'd0, dut.counter.max}, 31);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) drive("idle_after_rst", 1'b0, 1'b0, 'x);

        drive("load15", 1'b1, 1'b0, 5'd15);
        for (int i = 0; i < 18; i++) drive("dec_from15", 1'b0, 1'b1, 'x);

        drive("load9_with_down", 1'b1, 1'b1, 5'd9);
        drive("down_after9", 1'b0, 1'b1, 'x);

        drive("load31_noclip", 1'b1, 1'b0, 5'd31);
        for (int i = 0; i < 5; i++) drive("dec_from31", 1'b0, 1'b1, 'x);
        check("at26", {27'd0, current_count}, 26);

        @(negedge clk);
        #2;
        reset = 1'b0;
        model_count = 0;
        #1;
        check("midcount_async_rst", {27'd0, current_count}, 0);
        @(posedge clk);
        #1;
        check("rst_low_hold", {27'd0, current_count}, 0);
        check("max_after_rst", {27'd0, dut.counter.max}, 31);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive("no_resume_after_rst", 1'b0, 1'b1, 'x);

        drive("load20", 1'b1, 1'b0, 5'd20);
        for (int i = 0; i < 8; i++) drive("hold20", 1'b0, 1'b0, 'x);
        for (int i = 0; i < 3; i++) drive("dec_from20", 1'b0, 1'b1, 'x);
        check("at17", {27'd0, current_count}, 17);

        drive("load0_with_down", 1'b1, 1'b1, 5'd0);
        for (int i = 0; i < 3; i++) drive("zero_no_wrap", 1'b0, 1'b1, 'x);
        drive("load31_again", 1'b1, 1'b0, 5'd31);
        drive("dec_once", 1'b0, 1'b1, 'x);
        check("max_final", {27'd0, dut.counter.max}, 31);

        if (sb.size() != 0) check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
